// File: rtl/hazard_forward_unit.sv
// Execute-stage pipeline controller: tracks in-flight destination tags, drives operand
// forwarding selects, inserts load-use stalls and sequences taken-branch flushes.
module hazard_forward_unit #(
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [2:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_branch,
  input  logic             BRANCH_AND_ZERO,
  input  logic             mem_busy,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  typedef struct packed {
    logic       v;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       urs;
    logic       urt;
    logic [2:0] rd;
    logic       rw;
    logic       mr;
    logic       br;
  } ex_tag_t;

  typedef struct packed {
    logic       v;
    logic [2:0] rd;
    logic       rw;
    logic       mr;
  } mem_tag_t;

  typedef struct packed {
    logic       v;
    logic [2:0] rd;
    logic       rw;
  } wb_tag_t;

  // The take cycle is itself the first squash cycle, so FLUSH lasts FLUSH_DEPTH-1 cycles.
  localparam logic [1:0] FcntInit = (FLUSH_DEPTH >= 2) ? 2'(FLUSH_DEPTH - 2) : 2'd0;

  ex_tag_t  ex_q, ex_d;
  mem_tag_t mem_q, mem_d;
  wb_tag_t  wb_q, wb_d;
  state_e   state_q, state_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic take, luse;

  assign take = ex_q.v & ex_q.br & BRANCH_AND_ZERO;
  assign luse = id_valid & ex_q.v & ex_q.mr & ex_q.rw &
                ((id_uses_rs & (id_rs == ex_q.rd)) | (id_uses_rt & (id_rt == ex_q.rd)));

  // A load in MEM is never a forwarding source; the load-use stall keeps it from being needed.
  always_comb begin
    ForwardA = 2'b00;
    if (mem_q.v && mem_q.rw && !mem_q.mr && mem_q.rd == ex_q.rs && ex_q.urs) begin
      ForwardA = 2'b10;
    end else if (wb_q.v && wb_q.rw && wb_q.rd == ex_q.rs && ex_q.urs) begin
      ForwardA = 2'b01;
    end
  end

  always_comb begin
    ForwardB = 2'b00;
    if (mem_q.v && mem_q.rw && !mem_q.mr && mem_q.rd == ex_q.rt && ex_q.urt) begin
      ForwardB = 2'b10;
    end else if (wb_q.v && wb_q.rw && wb_q.rd == ex_q.rt && ex_q.urt) begin
      ForwardB = 2'b01;
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (take) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      if (FLUSH_DEPTH > 1) begin
        state_d = StFlush;
        fcnt_d  = FcntInit;
      end
    end else if (state_q == StFlush) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (fcnt_q == 2'd0) state_d = StRun;
      else                fcnt_d  = fcnt_q - 2'd1;
    end else if (luse) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!mem_busy) begin
      wb_d.v    = mem_q.v;
      wb_d.rd   = mem_q.rd;
      wb_d.rw   = mem_q.rw;
      mem_d.v   = ex_q.v;
      mem_d.rd  = ex_q.rd;
      mem_d.rw  = ex_q.rw;
      mem_d.mr  = ex_q.mr;
      ex_d.v    = id_valid & ~idex_bubble & ~ifid_flush;
      ex_d.rs   = id_rs;
      ex_d.rt   = id_rt;
      ex_d.urs  = id_uses_rs;
      ex_d.urt  = id_uses_rt;
      ex_d.rd   = id_rd;
      ex_d.rw   = id_regwrite;
      ex_d.mr   = id_memread;
      ex_d.br   = id_branch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      state_q     <= StRun;
      fcnt_q      <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
